onehot_mask_decoder: RTL and testbench
======================================

# onehot_mask_decoder

Streaming index-to-mask decoder: the inverse of the priority encoder. It accepts a stream of binary bit indices under a valid/ready handshake and decodes each index to one-hot. It ORs the decoded bits into an accumulator and, on the beat flagged `last_i`, emits the rebuilt `DATA_WIDTH`-bit mask on a registered valid/ready output. It also flags duplicate and out-of-range indices. It sits on the request-reconstruction side of arbitration paths, where encoded grants and requests travel as indices.

## Interface
- `DATA_WIDTH`, 8: mask width; index width is `IW = $clog2(DATA_WIDTH)`; `DATA_WIDTH` >= 2, need not be a power of 2.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `data_i`  in  IW  bit index to set.
- `valid_i`  in  1  input beat valid.
- `last_i`  in  1  final index of the current mask; qualified by `valid_i`.
- `ready_o`  out  1  input beat accepted when `valid_i && ready_o`.
- `data_o`  out  DATA_WIDTH  rebuilt mask.
- `valid_o`  out  1  `data_o`/flags valid.
- `ready_i`  in  1  downstream accepts output when `valid_o && ready_i`.
- `dup_o`  out  1  some index occurred more than once in this mask; qualified by `valid_o`.
- `range_err_o`  out  1  some index >= `DATA_WIDTH` occurred in this mask; qualified by `valid_o`.

## Operation
- State: accumulator `acc` (DATA_WIDTH), sticky `dup_acc`, `rerr_acc`, output register {`data_o`, `dup_o`, `range_err_o`, `valid_o`}, `alive` flop.
- `alive`: 0 in reset, 1 from the first edge after deassertion.
- `ready_o = alive && (!valid_o || ready_i)`. This is a combinational path from `ready_i`; it is permitted and documented.
- Accepted beat, in range (`data_i < DATA_WIDTH`): `hit = acc[data_i]`; `dup` term = `dup_acc | hit`; `next = acc | (1 << data_i)`.
- Accepted beat, out of range: `acc` unchanged; `rerr` term = 1; no bit set; no dup check.
- Accepted beat with `last_i=0`: `acc <= next`; sticky flags updated.
- Accepted beat with `last_i=1`:
  - `data_o <= next`, `dup_o`/`range_err_o` <= updated sticky values, `valid_o <= 1`.
  - `acc`, `dup_acc`, `rerr_acc` <= 0, so the next mask starts clean.
- Output handshake: `valid_o && ready_i` with no new last beat -> `valid_o <= 0`. A simultaneous last beat reloads the output register and keeps `valid_o=1` (back-to-back masks, no bubble).
- While `valid_o && !ready_i`: `data_o`, `dup_o`, `range_err_o` are held stable, and `ready_o=0`, so no input is accepted, including non-last beats.
- Single-beat mask (`last_i=1` on the first beat) is legal; the output is one-hot or zero.
- Mask of only out-of-range beats: `data_o=0`, `range_err_o=1`.
- Inputs when `valid_i=0` are ignored. `data_i`/`last_i` are don't-care unless `valid_i=1`.
- Reset (async, any time, including mid-mask or with output stalled):
  - `acc`, `data_o`, flags, `valid_o`, `alive` <= 0; the partial mask is discarded.
  - `ready_o=0` while `rst_n_i=0` and on the first edge after deassertion.

## Timing
- Reset values: `data_o=0`, `valid_o=0`, `dup_o=0`, `range_err_o=0`, `ready_o=0`.
- Latency: the mask is visible with `valid_o=1` the cycle after the edge accepting the last beat (1 cycle).
- Throughput: one index per cycle. A stream of single-beat masks sustains one mask per cycle with `ready_i=1`.
- No combinational path from `data_i`/`valid_i`/`last_i` to any output.

## Test plan
- Reset/idle: `rst_n_i` low then high, `valid_i=0` -> all outputs 0; `ready_o=1` from the 2nd edge after deassertion.
- Multi-beat (W=8): indices 0, 3, 7 with `last_i` on 7, `ready_i=1` -> one cycle later `data_o=8'h89`, `valid_o=1`, `dup_o=0`, `range_err_o=0`, for exactly one cycle.
- Duplicate: indices 5, 5(last) -> `data_o=8'h20`, `dup_o=1`. A following single beat 2(last) -> `data_o=8'h04`, `dup_o=0` (flags cleared).
- Range (W=6, IW=3): indices 6, 1(last) -> `data_o=6'h02`, `range_err_o=1`. Single beat 7(last) -> `data_o=0`, `range_err_o=1`.
- Backpressure: mask `8'h11` completes with `ready_i=0` for 4 cycles -> `data_o` held and `ready_o=0` throughout. Raise `ready_i` with next beat 6(last) presented -> that edge accepts the output and the beat; `data_o=8'h40` and `valid_o` stays 1.
- Reset mid-operation: accept indices 1, 2, assert `rst_n_i` low, release, send 4(last) -> `data_o=8'h10` (partial mask discarded).

Source files
------------

// File: rtl/onehot_mask_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_mask_decoder
//  Description : Streaming index-to-mask decoder. Each accepted beat carries a
//                binary bit index; the decoded one-hot bits are ORed into an
//                accumulator, and the beat flagged last_i publishes the rebuilt
//                mask (plus duplicate / out-of-range flags) on a registered
//                valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_mask_decoder #(
  parameter  int DATA_WIDTH = 8,
  localparam int IW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [IW-1:0]         data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  dup_o,
  output logic                  range_err_o
);

  // DATA_WIDTH always fits in IW+1 bits, so indices are compared one bit wider
  // to catch values >= DATA_WIDTH when the width is not a power of two.
  localparam logic [IW:0] c_WIDTH = (IW+1)'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  dup_acc_q, dup_acc_d;
  logic                  rerr_acc_q, rerr_acc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dup_q, dup_d;
  logic                  rerr_q, rerr_d;
  logic                  valid_q, valid_d;
  logic                  alive_q;

  logic [IW:0]           w_index;
  logic [DATA_WIDTH-1:0] w_onehot;
  logic                  w_in_range;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  w_dup_next;
  logic                  w_rerr_next;
  logic                  w_accept;

  assign w_index = {1'b0, data_i};

  // Out-of-range indices match no decoder output, so they leave the mask alone.
  generate
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_decode
      assign w_onehot[g] = (w_index == (IW+1)'(g));
    end
  endgenerate

  assign w_in_range  = (w_index < c_WIDTH);
  assign w_hit       = |(acc_q & w_onehot);
  assign w_next      = acc_q | w_onehot;
  assign w_dup_next  = dup_acc_q | w_hit;
  assign w_rerr_next = rerr_acc_q | ~w_in_range;

  // Input is accepted only when the output slot is free or draining this cycle;
  // this leaves a deliberate combinational path from ready_i to ready_o.
  assign ready_o  = alive_q & (~valid_q | ready_i);
  assign w_accept = valid_i & ready_o;

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign dup_o       = dup_q;
  assign range_err_o = rerr_q;

  // Next-state: accumulate on non-last beats, publish and clear on last beats.
  always_comb begin
    acc_d      = acc_q;
    dup_acc_d  = dup_acc_q;
    rerr_acc_d = rerr_acc_q;
    data_d     = data_q;
    dup_d      = dup_q;
    rerr_d     = rerr_q;
    valid_d    = valid_q;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (w_accept) begin
      if (last_i) begin
        data_d     = w_next;
        dup_d      = w_dup_next;
        rerr_d     = w_rerr_next;
        valid_d    = 1'b1;
        acc_d      = '0;
        dup_acc_d  = 1'b0;
        rerr_acc_d = 1'b0;
      end else begin
        acc_d      = w_next;
        dup_acc_d  = w_dup_next;
        rerr_acc_d = w_rerr_next;
      end
    end
  end

  // State registers; reset discards any partial mask and pending output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q      <= '0;
      dup_acc_q  <= 1'b0;
      rerr_acc_q <= 1'b0;
      data_q     <= '0;
      dup_q      <= 1'b0;
      rerr_q     <= 1'b0;
      valid_q    <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      dup_acc_q  <= dup_acc_d;
      rerr_acc_q <= rerr_acc_d;
      data_q     <= data_d;
      dup_q      <= dup_d;
      rerr_q     <= rerr_d;
      valid_q    <= valid_d;
      alive_q    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_mask_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_mask_decoder
//  Description : Self-checking bench; drives one index stream into an 8-bit
//                and a 6-bit instance and compares both against a model that
//                rebuilds each mask from the list of indices it received.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_mask_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] data;
  logic       valid;
  logic       last;
  logic       ready_in;

  logic       ready8, valid8, dup8, rerr8;
  logic [7:0] dout8;
  logic       ready6, valid6, dup6, rerr6;
  logic [5:0] dout6;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Model state: indices of the mask under construction and published outputs.
  int         q[$];
  bit         m_alive;
  bit         m_valid;
  logic [7:0] m_d8;
  logic [5:0] m_d6;
  bit         m_dup8, m_rerr8, m_dup6, m_rerr6;

  always #5 clk = ~clk;

  onehot_mask_decoder #(.DATA_WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready8), .data_o(dout8), .valid_o(valid8), .ready_i(ready_in),
    .dup_o(dup8), .range_err_o(rerr8)
  );

  onehot_mask_decoder #(.DATA_WIDTH(6)) u_dut6 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready6), .data_o(dout6), .valid_o(valid6), .ready_i(ready_in),
    .dup_o(dup6), .range_err_o(rerr6)
  );

  // Mask = set of distinct in-range indices; dup = some in-range value seen
  // twice; rerr = some value at or above the width.
  function automatic void build(input int w, output logic [7:0] mask,
                                output bit dup, output bit rerr);
    mask = '0;
    dup  = 1'b0;
    rerr = 1'b0;
    foreach (q[i]) if (q[i] >= w) rerr = 1'b1;
    for (int b = 0; b < w; b++) begin
      int n = 0;
      foreach (q[i]) if (q[i] == b) n++;
      if (n > 0) mask[b] = 1'b1;
      if (n > 1) dup = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_alive = 0; m_valid = 0; m_d8 = '0; m_d6 = '0;
    m_dup8 = 0; m_rerr8 = 0; m_dup6 = 0; m_rerr6 = 0;
    q.delete();
  endtask

  // Drive one cycle at the falling edge, advance the model across the rising edge.
  task automatic drive_cycle(input bit v, input int idx, input bit l, input bit r);
    bit         acc;
    logic [7:0] t;
    @(negedge clk);
    valid = v; data = idx[2:0]; last = l; ready_in = r;
    acc = v && m_alive && (!m_valid || r);
    @(posedge clk);
    if (rst_n) begin
      if (m_valid && r) m_valid = 0;
      if (acc) begin
        q.push_back(idx);
        if (l) begin
          build(8, t, m_dup8, m_rerr8); m_d8 = t;
          build(6, t, m_dup6, m_rerr6); m_d6 = t[5:0];
          m_valid = 1;
          q.delete();
        end
      end
      m_alive = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 0; data = '0; last = 0; ready_in = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (dout8 !== 8'h00 || valid8 !== 1'b0) begin failed++; $display("FAIL reset_out8 data=%h valid=%b exp data=00 valid=0", dout8, valid8); end else passed++;
    total++; if (dup8 !== 1'b0 || rerr8 !== 1'b0) begin failed++; $display("FAIL reset_flags8 dup=%b rerr=%b exp 0 0", dup8, rerr8); end else passed++;
    total++; if (ready8 !== 1'b0 || ready6 !== 1'b0) begin failed++; $display("FAIL reset_ready ready8=%b ready6=%b exp 0 0", ready8, ready6); end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (ready8 !== 1'b0) begin failed++; $display("FAIL ready_after_release got=%b exp=0", ready8); end else passed++;
    drive_cycle(0, 0, 0, 1);
    total++; if (ready8 !== 1'b1 || ready6 !== 1'b1) begin failed++; $display("FAIL ready_alive ready8=%b ready6=%b exp 1 1", ready8, ready6); end else passed++;
    total++; if (valid8 !== 1'b0 || dout6 !== 6'h00) begin failed++; $display("FAIL idle_out valid8=%b data6=%h exp 0 00", valid8, dout6); end else passed++;
  endtask

  task automatic test_multi_beat();
    drive_cycle(1, 0, 0, 1);
    total++; if (valid8 !== 1'b0) begin failed++; $display("FAIL multi_early_valid got=%b exp=0", valid8); end else passed++;
    drive_cycle(1, 3, 0, 1);
    drive_cycle(1, 7, 1, 1);
    total++; if (dout8 !== 8'h89 || valid8 !== 1'b1) begin failed++; $display("FAIL multi_data8 data=%h valid=%b exp 89 1", dout8, valid8); end else passed++;
    total++; if (dup8 !== 1'b0 || rerr8 !== 1'b0) begin failed++; $display("FAIL multi_flags8 dup=%b rerr=%b exp 0 0", dup8, rerr8); end else passed++;
    total++; if (dout6 !== 6'h09 || rerr6 !== 1'b1) begin failed++; $display("FAIL multi_data6 data=%h rerr=%b exp 09 1", dout6, rerr6); end else passed++;
    drive_cycle(0, 0, 0, 1);
    total++; if (valid8 !== 1'b0 || valid6 !== 1'b0) begin failed++; $display("FAIL multi_one_cycle valid8=%b valid6=%b exp 0 0", valid8, valid6); end else passed++;
  endtask

  task automatic test_duplicate();
    drive_cycle(1, 5, 0, 1);
    drive_cycle(1, 5, 1, 1);
    total++; if (dout8 !== 8'h20 || dup8 !== 1'b1 || valid8 !== 1'b1) begin failed++; $display("FAIL dup_mask data=%h dup=%b valid=%b exp 20 1 1", dout8, dup8, valid8); end else passed++;
    drive_cycle(1, 2, 1, 1);
    total++; if (dout8 !== 8'h04 || dup8 !== 1'b0 || valid8 !== 1'b1) begin failed++; $display("FAIL dup_cleared data=%h dup=%b valid=%b exp 04 0 1", dout8, dup8, valid8); end else passed++;
    drive_cycle(0, 0, 0, 1);
  endtask

  task automatic test_range();
    drive_cycle(1, 6, 0, 1);
    drive_cycle(1, 1, 1, 1);
    total++; if (dout6 !== 6'h02 || rerr6 !== 1'b1 || valid6 !== 1'b1) begin failed++; $display("FAIL range_mask6 data=%h rerr=%b valid=%b exp 02 1 1", dout6, rerr6, valid6); end else passed++;
    total++; if (dout8 !== 8'h42 || rerr8 !== 1'b0) begin failed++; $display("FAIL range_mask8 data=%h rerr=%b exp 42 0", dout8, rerr8); end else passed++;
    drive_cycle(1, 7, 1, 1);
    total++; if (dout6 !== 6'h00 || rerr6 !== 1'b1 || valid6 !== 1'b1) begin failed++; $display("FAIL range_only6 data=%h rerr=%b valid=%b exp 00 1 1", dout6, rerr6, valid6); end else passed++;
    total++; if (dout8 !== 8'h80 || rerr8 !== 1'b0) begin failed++; $display("FAIL range_only8 data=%h rerr=%b exp 80 0", dout8, rerr8); end else passed++;
    drive_cycle(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 4, 1, 0);
    total++; if (dout8 !== 8'h11 || valid8 !== 1'b1 || ready8 !== 1'b0) begin failed++; $display("FAIL bp_first data=%h valid=%b ready=%b exp 11 1 0", dout8, valid8, ready8); end else passed++;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 6, 1, 0);
      total++; if (dout8 !== 8'h11 || valid8 !== 1'b1 || ready8 !== 1'b0) begin failed++; $display("FAIL bp_hold%0d data=%h valid=%b ready=%b exp 11 1 0", i, dout8, valid8, ready8); end else passed++;
    end
    drive_cycle(1, 6, 1, 1);
    total++; if (dout8 !== 8'h40 || valid8 !== 1'b1) begin failed++; $display("FAIL bp_release data=%h valid=%b exp 40 1", dout8, valid8); end else passed++;
    total++; if (dout6 !== 6'h00 || rerr6 !== 1'b1) begin failed++; $display("FAIL bp_release6 data=%h rerr=%b exp 00 1", dout6, rerr6); end else passed++;
    drive_cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1, 1, 0, 1);
    drive_cycle(1, 2, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ready8 !== 1'b0 || valid8 !== 1'b0 || dout8 !== 8'h00) begin failed++; $display("FAIL async_reset ready=%b valid=%b data=%h exp 0 0 00", ready8, valid8, dout8); end else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(1, 4, 1, 1);
    total++; if (dout8 !== 8'h10 || valid8 !== 1'b1 || dup8 !== 1'b0) begin failed++; $display("FAIL reset_discard data=%h valid=%b dup=%b exp 10 1 0", dout8, valid8, dup8); end else passed++;
    drive_cycle(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit exp_ready;
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      exp_ready = m_alive && (!m_valid || ready_in);
      total++; if (ready8 !== exp_ready || ready6 !== exp_ready) begin failed++; $display("FAIL rnd_ready cyc=%0d r8=%b r6=%b exp=%b", n, ready8, ready6, exp_ready); end else passed++;
      total++; if (valid8 !== m_valid || valid6 !== m_valid) begin failed++; $display("FAIL rnd_valid cyc=%0d v8=%b v6=%b exp=%b", n, valid8, valid6, m_valid); end else passed++;
      total++; if (dout8 !== m_d8) begin failed++; $display("FAIL rnd_data8 cyc=%0d got=%h exp=%h", n, dout8, m_d8); end else passed++;
      total++; if (dout6 !== m_d6) begin failed++; $display("FAIL rnd_data6 cyc=%0d got=%h exp=%h", n, dout6, m_d6); end else passed++;
      total++; if (dup8 !== m_dup8 || rerr8 !== m_rerr8) begin failed++; $display("FAIL rnd_flags8 cyc=%0d dup=%b rerr=%b exp %b %b", n, dup8, rerr8, m_dup8, m_rerr8); end else passed++;
      total++; if (dup6 !== m_dup6 || rerr6 !== m_rerr6) begin failed++; $display("FAIL rnd_flags6 cyc=%0d dup=%b rerr=%b exp %b %b", n, dup6, rerr6, m_dup6, m_rerr6); end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_multi_beat();
    test_duplicate();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
